// File: rtl/sqrt_iter_core.sv
// Restoring integer square root: one root bit per clock, returning the floor root and exact remainder.
// Responder side of the enable/flush/done multicycle handshake.
module sqrt_iter_core #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned COUNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [2*WIDTH-1:0]   src,
    output logic [WIDTH-1:0]     sqrt,
    output logic [WIDTH:0]       remnant,
    output logic                 done
);

    localparam int unsigned RW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [2*WIDTH-1:0]     rad;
    logic [RW-1:0]          r;
    logic [WIDTH-1:0]       q;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   done_q;

    logic [RW-1:0]          t_c;
    logic [RW-1:0]          d_c;

    // Trial subtraction; the true value of d always fits RW bits, so the MSB is its sign.
    always_comb begin
        t_c = (r << 2) | RW'(rad[2*WIDTH-1 -: 2]);
        d_c = t_c - {q, 2'b01};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rad    <= '0;
            r      <= '0;
            q      <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        rad   <= src;
                        r     <= '0;
                        q     <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (d_c[RW-1]) begin
                        r <= t_c;
                        q <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        r <= d_c;
                        q <= {q[WIDTH-2:0], 1'b1};
                    end
                    rad <= {rad[2*WIDTH-3:0], 2'b00};
                    cnt <= cnt + COUNT_WIDTH'(1);
                    if (cnt == COUNT_WIDTH'(WIDTH - 1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign sqrt    = q;
    assign remnant = r[WIDTH:0];
    assign done    = done_q;

endmodule

// File: tb/tb_sqrt_iter_core.sv
// Bench for sqrt_iter_core: a WIDTH=4 and a WIDTH=26 instance checked against an arithmetic floor-sqrt model.
module tb_sqrt_iter_core;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        sel;
    logic [63:0] src;

    logic        en_s, en_l;
    logic [7:0]  src_s;
    logic [51:0] src_l;
    logic [3:0]  sqrt_s;
    logic [4:0]  rem_s;
    logic        done_s;
    logic [25:0] sqrt_l;
    logic [26:0] rem_l;
    logic        done_l;

    logic        cur_done;
    logic [63:0] cur_sqrt;
    logic [63:0] cur_rem;

    logic        chk;
    logic        chk_zero;
    logic        exp_done;
    logic [63:0] exp_sqrt;
    logic [63:0] exp_rem;

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign en_s  = en & ~sel;
    assign en_l  = en & sel;
    assign src_s = src[7:0];
    assign src_l = src[51:0];

    sqrt_iter_core #(.WIDTH(4)) u_small (
        .clk     (clk),
        .rst     (rst),
        .enable  (en_s),
        .flush   (flush),
        .src     (src_s),
        .sqrt    (sqrt_s),
        .remnant (rem_s),
        .done    (done_s)
    );

    sqrt_iter_core #(.WIDTH(26)) u_large (
        .clk     (clk),
        .rst     (rst),
        .enable  (en_l),
        .flush   (flush),
        .src     (src_l),
        .sqrt    (sqrt_l),
        .remnant (rem_l),
        .done    (done_l)
    );

    always_comb begin
        if (sel) begin
            cur_done = done_l;
            cur_sqrt = 64'(sqrt_l);
            cur_rem  = 64'(rem_l);
        end else begin
            cur_done = done_s;
            cur_sqrt = 64'(sqrt_s);
            cur_rem  = 64'(rem_s);
        end
    end

    // Floor square root by greedy bit setting against a plain square.
    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0] s;
        logic [63:0] c;
        s = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            c = s | (64'd1 << b);
            if (c * c <= x) s = c;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t sel=%0b got %0d want %0d", name, $time, sel, got, want);
        end
    endtask

    // Every cycle: done must match its expected level; while done the result must match.
    always @(negedge clk) begin
        if (chk) begin
            check("done", 64'(cur_done), 64'(exp_done));
            if (exp_done) begin
                check("sqrt", cur_sqrt, exp_sqrt);
                check("remnant", cur_rem, exp_rem);
            end else if (chk_zero) begin
                check("sqrt_zero", cur_sqrt, 64'd0);
                check("remnant_zero", cur_rem, 64'd0);
            end
        end
    end

    task automatic request(input logic [63:0] x, input logic [63:0] es, input logic [63:0] er,
                           input int hold);
        int w;
        w = sel ? 26 : 4;
        @(negedge clk);
        chk_zero = 1'b0;
        src      = x;
        en       = 1'b1;
        exp_sqrt = es;
        exp_rem  = er;
        for (int k = 0; k <= w; k++) begin
            @(posedge clk);
            exp_done = (k >= w);
            if (k == 0) begin
                @(negedge clk);
                src = ~x;
            end
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        exp_done = 1'b0;
    endtask

    task automatic request_model(input logic [63:0] x);
        logic [63:0] s;
        s = isqrt(x);
        request(x, s, x - s * s, 0);
    endtask

    initial begin
        logic [63:0] x;
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        en       = 1'b0;
        flush    = 1'b0;
        sel      = 1'b0;
        src      = 64'd0;
        chk      = 1'b0;
        chk_zero = 1'b1;
        exp_done = 1'b0;
        exp_sqrt = 64'd0;
        exp_rem  = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk = 1'b1;
        repeat (2) @(posedge clk);

        check("model_144", isqrt(64'd144), 64'd12);
        check("model_255", isqrt(64'd255), 64'd15);
        check("model_2p50", isqrt(64'd1 << 50), 64'd1 << 25);
        check("model_2p51m1", isqrt((64'd1 << 51) - 64'd1), 64'd47453132);

        // Directed WIDTH=4 cases.
        request(64'h90, 64'd12, 64'd0, 0);
        request(64'hFF, 64'd15, 64'd30, 0);
        request(64'h00, 64'd0, 64'd0, 0);
        request(64'h02, 64'd1, 64'd1, 0);
        request(64'h90, 64'd12, 64'd0, 10);
        request(64'hFF, 64'd15, 64'd30, 0);

        // Enable dropped while busy: a single-cycle done pulse.
        @(negedge clk);
        src = 64'h02; en = 1'b1; exp_sqrt = 64'd1; exp_rem = 64'd1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        exp_done = 1'b1;
        @(posedge clk);
        exp_done = 1'b0;
        repeat (2) @(posedge clk);

        // Flush mid-computation: done never rises.
        @(negedge clk);
        src = 64'hFF; en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1; en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        repeat (6) @(posedge clk);
        request(64'h90, 64'd12, 64'd0, 0);

        // Reset while busy, then reset held together with enable.
        @(negedge clk);
        src = 64'hFF; en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        chk_zero = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        repeat (2) @(posedge clk);
        request(64'hFF, 64'd15, 64'd30, 0);

        for (int i = 0; i < 100; i++) begin
            request_model(64'($urandom_range(0, 255)));
        end

        // WIDTH=26 instance.
        @(negedge clk);
        sel = 1'b1;
        repeat (2) @(posedge clk);
        request(64'd1 << 50, 64'd1 << 25, 64'd0, 0);
        request((64'd1 << 51) - 64'd1, 64'd47453132,
                ((64'd1 << 51) - 64'd1) - 64'd47453132 * 64'd47453132, 0);
        request((64'd1 << 52) - 64'd1, (64'd1 << 26) - 64'd1, (64'd1 << 27) - 64'd2, 0);
        request(64'd0, 64'd0, 64'd0, 0);
        for (int i = 0; i < 2000; i++) begin
            x = {32'($urandom), 32'($urandom)} & ((64'd1 << 52) - 64'd1);
            if (i % 40 == 1) x = isqrt(x) * isqrt(x);
            if (i % 40 == 2) x = (isqrt(x) + 64'd1) * (isqrt(x) + 64'd1) - 64'd1;
            request_model(x);
        end

        @(negedge clk);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
